data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001: Parameter DATA_WIDTH, default 16, is the word width in bits.
REQ-002: Parameter ADDR_WIDTH, default 16, is the byte-address width.
REQ-003: Parameter INDEX_BITS, default 8, is the word-index width; storage depth is 2^INDEX_BITS words.
REQ-004: Parameter LATENCY, default 4, is the number of cycles from read accept to data_valid; legal range is 2..8.
REQ-005: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-006: Port rst, input, 1 bit, is the synchronous, active-high reset.
REQ-007: Port enable, input, 1 bit, is the request strobe; one request per cycle.
REQ-008: Port wr, input, 1 bit, selects the request type: 1 = write, 0 = read; it is qualified by enable.
REQ-009: Port addr, input, ADDR_WIDTH bits, is the byte address; addr[0] is ignored.
REQ-010: Port data_in, input, DATA_WIDTH bits, is the write data.
REQ-011: Port data_out, output, DATA_WIDTH bits, is the read return data.
REQ-012: Port data_valid, output, 1 bit, is a 1-cycle pulse marking data_out valid.
REQ-013: Port busy, output, 1 bit, is high while any read is in flight.

Function
REQ-014: The word index SHALL be addr[INDEX_BITS:1]; address bits above INDEX_BITS SHALL be ignored (aliasing).
REQ-015: Every request with enable=1 and rst=0 SHALL be accepted that cycle; there is no back-pressure.
REQ-016: A write SHALL commit data_in to storage at the accepting edge and SHALL produce no data_valid.
REQ-017: A read SHALL sample storage at the accepting edge, using the contents before any same-edge commit, and SHALL carry that snapshot through a LATENCY-stage pipeline.
REQ-018: A read accepted at edge N SHALL drive data_valid=1 and data_out=snapshot during the cycle following edge N+LATENCY-1.
REQ-019: Back-to-back reads SHALL produce back-to-back data_valid pulses in order; up to LATENCY reads may be in flight.
REQ-020: A write after a read to the same index SHALL NOT alter the in-flight read data.
REQ-021: A read after a write to the same index SHALL return the written data.
REQ-022: data_out SHALL be 0 whenever data_valid=0.
REQ-023: busy SHALL be the OR of all pipeline-stage valid bits, including the stage driving data_valid.

Reset
REQ-024: While rst=1, all pipeline valid bits SHALL clear, data_valid=0, data_out=0 and busy=0, effective at the next edge.
REQ-025: A request presented with rst=1 SHALL be discarded; a write SHALL NOT commit.
REQ-026: Reads in flight at reset SHALL be dropped and SHALL never return data_valid.
REQ-027: Storage contents SHALL NOT be altered by rst.

Structure
REQ-028: DATA_WIDTH, ADDR_WIDTH, INDEX_BITS and LATENCY defaults SHALL live in shared package mem_pkg.
REQ-029: The latency pipeline SHALL be one sub-module, mem_lat_pipe, holding valid and data per stage with a synchronous clear.
REQ-030: Storage SHALL be a single-port array with a synchronous write and a read snapshot taken at accept.

Verification
REQ-031: Write 0xBEEF to addr 0x0010, then read addr 0x0010 -> data_valid occurs LATENCY cycles after the read accept with data_out=0xBEEF; no pulse occurs for the write.
REQ-032: Write 0x1111 to 0x0020, read 0x0020, then next cycle write 0x2222 to 0x0020 -> the read returns 0x1111; a later read returns 0x2222.
REQ-033: Four consecutive reads of 0x0000, 0x0002, 0x0004, 0x0006 preloaded with 1,2,3,4 -> four consecutive data_valid pulses returning 1,2,3,4; busy is high from the first accept through the last pulse.
REQ-034: Issue a read, then assert rst for 1 cycle two cycles later -> no data_valid ever appears; busy=0 after the reset edge; a prior write of 0xA5A5 is still readable afterwards.
REQ-035: Write 0x7777 to addr 0x0203 with INDEX_BITS=8 -> reads of 0x0002 and 0x0202 both return 0x7777.
REQ-036: Assert enable=1, wr=1 with data 0x5555 to 0x0040 while rst=1 -> a subsequent read of 0x0040 returns the value it held before the reset cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared defaults for the data memory responder and its latency pipeline.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_INDEX_BITS = 8;
    localparam int DEF_LATENCY    = 4;

    localparam int MIN_LATENCY = 2;
    localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-depth valid/data shift pipeline with synchronous clear; carries read
// snapshots from accept to the output stage.
module mem_lat_pipe #(
    parameter int STAGES = mem_pkg::DEF_LATENCY,
    parameter int WIDTH  = mem_pkg::DEF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    logic [STAGES-1:0] valid_reg;
    logic [WIDTH-1:0]  data_reg [STAGES];
    logic [STAGES-1:0] valid_next;
    logic [WIDTH-1:0]  data_next [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = in_valid;
                assign data_next[gi]  = in_data;
            end else begin : g_body
                assign valid_next[gi] = valid_reg[gi-1];
                assign data_next[gi]  = data_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_next[gi];
                end
                data_reg[gi] <= data_next[gi];
            end
        end
    endgenerate

    // Data is only meaningful alongside its valid bit, so gate it to zero otherwise.
    assign out_valid = valid_reg[STAGES-1];
    assign out_data  = valid_reg[STAGES-1] ? data_reg[STAGES-1] : '0;
    assign busy      = |valid_reg;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed single-port memory: writes commit immediately, reads return
// a snapshot taken at accept after a fixed LATENCY-cycle pipeline.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [INDEX_BITS-1:0] index;
    logic                  wr_commit;
    logic                  rd_accept;
    logic                  unused_addr_bits;

    // Byte address to word index; high bits alias and the byte-lane bit is dropped.
    assign index            = addr[INDEX_BITS:1];
    assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:INDEX_BITS+1], addr[0]};

    assign wr_commit = enable && wr && !rst;
    assign rd_accept = enable && !wr && !rst;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[index] <= data_in;
        end
    end

    // The pipeline head samples mem[index] on the accept edge, so a read sees
    // the contents before any write committing on that same edge.
    mem_lat_pipe #(
        .STAGES (LATENCY),
        .WIDTH  (DATA_WIDTH)
    ) u_lat_pipe (
        .clk       (clk),
        .srst      (rst),
        .in_valid  (rd_accept),
        .in_data   (mem[index]),
        .out_valid (data_valid),
        .out_data  (data_out),
        .busy      (busy)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at default parameters.
module tb_data_mem_responder;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;

    int checks;
    int fails;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for one edge, then return to idle 1 time unit later.
    task automatic drive(input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        wr      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for data_valid; cnt counts cycles since the accept edge, -1 on timeout.
    task automatic wait_valid(input int start, output int cnt, output logic [15:0] d);
        cnt = start;
        while (data_valid !== 1'b1 && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (data_valid !== 1'b1) cnt = -1;
        d = data_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (data_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b expected 0", data_valid);
        end
        checks++;
        if (data_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0000", data_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        int cnt;
        logic [15:0] d;
        drive(1'b1, 16'h0010, 16'hBEEF);
        for (int i = 0; i < LAT + 1; i++) begin
            checks++;
            if (data_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL write_no_pulse: cycle %0d valid=%b busy=%b expected 0/0", i, data_valid, busy);
            end
            tick();
        end
        drive(1'b0, 16'h0010, 16'h0000);
        wait_valid(1, cnt, d);
        checks++;
        if (cnt !== LAT) begin
            fails++;
            $display("FAIL read_latency: got %0d expected %0d", cnt, LAT);
        end
        checks++;
        if (d !== 16'hBEEF) begin
            fails++;
            $display("FAIL read_data: got %h expected beef", d);
        end
        tick();
        checks++;
        if (data_valid !== 1'b0 || data_out !== 16'h0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_pulse_end: valid=%b data=%h busy=%b expected 0/0000/0", data_valid, data_out, busy);
        end
        $display("test_write_read: latency=%0d data=%h", cnt, d);
    endtask

    task automatic test_write_after_read();
        int cnt;
        logic [15:0] d;
        drive(1'b1, 16'h0020, 16'h1111);
        drive(1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 16'h0020, 16'h2222);
        wait_valid(2, cnt, d);
        checks++;
        if (cnt !== LAT || d !== 16'h1111) begin
            fails++;
            $display("FAIL war_inflight: got lat=%0d data=%h expected lat=%0d data=1111", cnt, d, LAT);
        end
        tick();
        drive(1'b0, 16'h0020, 16'h0000);
        wait_valid(1, cnt, d);
        checks++;
        if (cnt !== LAT || d !== 16'h2222) begin
            fails++;
            $display("FAIL raw_later: got lat=%0d data=%h expected lat=%0d data=2222", cnt, d, LAT);
        end
        tick();
        $display("test_write_after_read: later read data=%h", d);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            a = 16'(2 * i);
            e = 16'(i + 1);
            drive(1'b1, a, e);
        end
        for (int i = 0; i < 4; i++) begin
            a = 16'(2 * i);
            drive(1'b0, a, 16'h0000);
            checks++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_busy_issue: read %0d busy=%b expected 1", i, busy);
            end
        end
        for (int i = 0; i < 4; i++) begin
            e = 16'(i + 1);
            checks++;
            if (data_valid !== 1'b1 || data_out !== e || busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_pulse: idx %0d valid=%b data=%h busy=%b expected 1/%h/1", i, data_valid, data_out, busy, e);
            end
            tick();
        end
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: valid=%b busy=%b expected 0/0", data_valid, busy);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_flush();
        int cnt;
        logic [15:0] d;
        int seen;
        drive(1'b1, 16'h0030, 16'hA5A5);
        drive(1'b0, 16'h0030, 16'h0000);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_busy_before: got %b expected 1", busy);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_after_rst: busy=%b valid=%b expected 0/0", busy, data_valid);
        end
        seen = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            if (data_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_dropped: got %0d pulses expected 0", seen);
        end
        drive(1'b0, 16'h0030, 16'h0000);
        wait_valid(1, cnt, d);
        checks++;
        if (cnt !== LAT || d !== 16'hA5A5) begin
            fails++;
            $display("FAIL flush_storage: got lat=%0d data=%h expected lat=%0d data=a5a5", cnt, d, LAT);
        end
        tick();
        $display("test_reset_flush: readback=%h", d);
    endtask

    task automatic test_alias();
        int cnt;
        logic [15:0] d;
        drive(1'b1, 16'h0203, 16'h7777);
        drive(1'b0, 16'h0002, 16'h0000);
        drive(1'b0, 16'h0202, 16'h0000);
        wait_valid(2, cnt, d);
        checks++;
        if (cnt !== LAT || d !== 16'h7777) begin
            fails++;
            $display("FAIL alias_0002: got lat=%0d data=%h expected lat=%0d data=7777", cnt, d, LAT);
        end
        tick();
        checks++;
        if (data_valid !== 1'b1 || data_out !== 16'h7777) begin
            fails++;
            $display("FAIL alias_0202: valid=%b data=%h expected 1/7777", data_valid, data_out);
        end
        tick();
        $display("test_alias done");
    endtask

    task automatic test_reset_write();
        int cnt;
        logic [15:0] d;
        drive(1'b1, 16'h0040, 16'h1234);
        rst     = 1'b1;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0040;
        data_in = 16'h5555;
        tick();
        rst     = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rstwr_idle: valid=%b busy=%b expected 0/0", data_valid, busy);
        end
        drive(1'b0, 16'h0040, 16'h0000);
        wait_valid(1, cnt, d);
        checks++;
        if (cnt !== LAT || d !== 16'h1234) begin
            fails++;
            $display("FAIL rstwr_discard: got lat=%0d data=%h expected lat=%0d data=1234", cnt, d, LAT);
        end
        tick();
        $display("test_reset_write: readback=%h", d);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        test_reset();
        test_write_read();
        test_write_after_read();
        test_back_to_back();
        test_reset_flush();
        test_alias();
        test_reset_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
